// File: rtl/rsa_job_sequencer.sv
// rsa_job_sequencer: accepts RSA jobs on a valid/ready stream and sequences one control core through
// its inverter and mod-exp phases. Optional per-phase wait timeout: define RSA_SEQ_TIMEOUT_EN.
module rsa_job_sequencer #(
  parameter int WIDTH       = 128,
  parameter int MASK_CYC    = 2,
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_p,
  input  logic [WIDTH-1:0]   req_q,
  input  logic               req_mode,
  input  logic [2*WIDTH-1:0] req_msg,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_msg,
  output logic               rsp_err,
  output logic               rsp_key_reused,
  output logic [WIDTH-1:0]   core_p,
  output logic [WIDTH-1:0]   core_q,
  output logic               core_encrypt_decrypt,
  output logic [2*WIDTH-1:0] core_msg_in,
  output logic               core_reset_inverter,
  output logic               core_reset_mod_exp,
  input  logic               core_inverter_finish,
  input  logic               core_mod_exp_finish,
  input  logic [2*WIDTH-1:0] core_msg_out,
  output logic               busy
);

  localparam int MW = $clog2(MASK_CYC + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INV_RST,
    S_INV_WAIT,
    S_EXP_RST,
    S_EXP_WAIT,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [MW-1:0]      r_mask_cnt;
  logic [WIDTH-1:0]   r_core_p;
  logic [WIDTH-1:0]   r_core_q;
  logic               r_core_mode;
  logic [2*WIDTH-1:0] r_core_msg;
  logic [WIDTH-1:0]   r_cache_p;
  logic [WIDTH-1:0]   r_cache_q;
  logic               r_cache_mode;
  logic               r_cache_valid;
  logic [2*WIDTH-1:0] r_rsp_msg;
  logic               r_rsp_err;
  logic               r_key_reused;

  logic w_accept;
  logic w_hit;
  logic w_mask_done;
  logic w_inv_done;
  logic w_exp_done;
  logic w_timeout;

  assign w_accept    = (r_state == S_IDLE) && req_valid;
  assign w_hit       = r_cache_valid && (req_p == r_cache_p) && (req_q == r_cache_q) &&
                       (req_mode == r_cache_mode);
  assign w_mask_done = (r_mask_cnt == MW'(MASK_CYC));
  assign w_inv_done  = (r_state == S_INV_WAIT) && w_mask_done && core_inverter_finish;
  assign w_exp_done  = (r_state == S_EXP_WAIT) && w_mask_done && core_mod_exp_finish;

`ifdef RSA_SEQ_TIMEOUT_EN
  logic [31:0] r_wait_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_INV_WAIT || r_state == S_EXP_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 32'd1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // An accepted finish on the last allowed cycle still wins over the timeout.
  assign w_timeout = (r_state == S_INV_WAIT || r_state == S_EXP_WAIT) &&
                     (r_wait_cnt == 32'(TIMEOUT_CYC - 1)) && !w_inv_done && !w_exp_done;
`else
  // Waits are unbounded; TIMEOUT_CYC only matters when the timeout is built in.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (req_valid) w_next = w_hit ? S_EXP_RST : S_INV_RST;
      S_INV_RST:  w_next = S_INV_WAIT;
      S_INV_WAIT: begin
        if (w_timeout) begin
          w_next = S_RESP;
        end else if (w_inv_done) begin
          w_next = S_EXP_RST;
        end
      end
      S_EXP_RST:  w_next = S_EXP_WAIT;
      S_EXP_WAIT: if (w_timeout || w_exp_done) w_next = S_RESP;
      S_RESP:     if (rsp_ready) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Mask counter restarts with every reset pulse so a stale finish cannot slip through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask_cnt <= '0;
    end else if (r_state == S_INV_WAIT || r_state == S_EXP_WAIT) begin
      if (!w_mask_done) r_mask_cnt <= r_mask_cnt + MW'(1);
    end else begin
      r_mask_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_core_p      <= '0;
      r_core_q      <= '0;
      r_core_mode   <= 1'b0;
      r_core_msg    <= '0;
      r_cache_p     <= '0;
      r_cache_q     <= '0;
      r_cache_mode  <= 1'b0;
      r_cache_valid <= 1'b0;
      r_rsp_msg     <= '0;
      r_rsp_err     <= 1'b0;
      r_key_reused  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_core_p     <= req_p;
        r_core_q     <= req_q;
        r_core_mode  <= req_mode;
        r_core_msg   <= req_msg;
        r_key_reused <= w_hit;
        r_rsp_err    <= 1'b0;
      end
      if (w_inv_done) begin
        r_cache_p     <= r_core_p;
        r_cache_q     <= r_core_q;
        r_cache_mode  <= r_core_mode;
        r_cache_valid <= 1'b1;
      end
      if (w_exp_done) begin
        r_rsp_msg <= core_msg_out;
      end
      if (w_timeout) begin
        r_rsp_msg     <= '0;
        r_rsp_err     <= 1'b1;
        r_cache_valid <= 1'b0;
      end
    end
  end

  assign req_ready            = (r_state == S_IDLE);
  assign busy                 = (r_state != S_IDLE);
  assign rsp_valid            = (r_state == S_RESP);
  assign rsp_msg              = r_rsp_msg;
  assign rsp_err              = r_rsp_err;
  assign rsp_key_reused       = r_key_reused;
  assign core_p               = r_core_p;
  assign core_q               = r_core_q;
  assign core_encrypt_decrypt = r_core_mode;
  assign core_msg_in          = r_core_msg;
  assign core_reset_inverter  = (r_state == S_INV_RST);
  assign core_reset_mod_exp   = (r_state == S_EXP_RST);

endmodule
